add_serial_rr_ctrl: RTL and testbench
=====================================

Name: add_serial_rr_ctrl

Overview:
- Round-robin controller that shares one 8-bit bit-serial adder (add_serial datapath) among NREQ requesters.
- Latches the granted requester's operands and pulses the adder's enable to load them.
- Counts out the serial ADD phase, because the adder has no done flag, then captures the result and returns it with a one-cycle ack.
- Sits between requester agents and the adder instance. The integrator inverts rst for the adder's active-high reset.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, operand width; equals the adder's serial cycle count. The adder is 8-bit, so W is fixed at 8.
- IDW, 2, width of requester index; must equal clog2(NREQ).
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock, all flops on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*W  operand A, requester i at bits [i*W +: W].
- b_in  in  NREQ*W  operand B, same packing.
- ack  out  NREQ  one-cycle completion pulse to the served requester.
- rsp_valid  out  1  one-cycle pulse, coincident with ack.
- rsp_id  out  IDW  index of served requester, valid with rsp_valid.
- rsp_sum  out  W  captured adder result, held until the next capture.
- busy  out  1  high in every state except IDLE.
- op_cnt  out  CNTW  completed operations, saturating.
- add_en  out  1  adder enable.
- add_a  out  W  adder operand A, registered.
- add_b  out  W  adder operand B, registered.
- add_out  in  W  adder result.

Behaviour:
- Reset (rst=0, async):
  - Outputs: ack, rsp_valid, rsp_id, rsp_sum, add_en, add_a, add_b, op_cnt all 0; busy=0.
  - Internal: state=IDLE, phase counter=0, last-grant pointer=NREQ-1 (so requester 0 has first priority).
- All outputs are registered. Release of reset is synchronous to clk.
- FSM states: IDLE, LOAD, RUN, CAPT, REL.
- IDLE:
  - If any req bit is high, grant g = first set bit searching from (last+1) mod NREQ upward with wrap.
  - Latch add_a=a_in[g], add_b=b_in[g], and g; go to LOAD.
  - If no req, stay in IDLE.
- LOAD: add_en=1 for exactly this cycle; phase counter=0; go to RUN.
- RUN:
  - add_en=0; counter increments each cycle.
  - After W cycles (counter==W-1 at the edge), go to CAPT.
- CAPT:
  - The adder is in its DONE state and add_out is valid.
  - At the edge, rsp_sum<=add_out, rsp_id<=g, rsp_valid<=1, ack[g]<=1; go to REL.
  - add_en stays 0 so the adder returns to its IDLE state.
- REL:
  - ack[g] and rsp_valid are high for this single cycle.
  - last<=g; op_cnt<=op_cnt+1, saturating at all-ones; go to IDLE.
- Latency: with req sampled high in IDLE at cycle 0, the states run LOAD at 1, RUN at 2..9, CAPT at 10, and ack at 11. Each operation occupies 12 cycles, which is also the back-to-back throughput.
- Requester rules:
  - Hold req and operands stable until ack.
  - Operands are only sampled in the IDLE cycle in which the grant is made; changes after the grant are ignored.
  - A req that is still high in the IDLE cycle after ack counts as a new request.
  - Dropping req before grant cancels it with no side effects.
  - Changes to req bits during LOAD..REL are not observed.
- Arithmetic: the result is the adder's W-bit output only. There is no carry-out, and overflow wraps.
- Simultaneous requests are resolved by the round-robin pointer only. No requester is starved: maximum wait is NREQ-1 operations.
- Reset mid-operation: everything returns to reset values immediately. No ack is issued for the aborted operation. A requester still holding req is re-arbitrated from scratch.
- States outside the defined set return to IDLE on the next clock.

Test Plan:
- Single request: after reset, req[0]=1, a=0x25, b=0x13. Required: add_en=1 only in cycle 1 with add_a=0x25, add_b=0x13; ack[0] and rsp_valid in cycle 11 only; rsp_id=0; rsp_sum=0x38; op_cnt=1.
- All requesters at once: req=4'b1111 held, each requester drops req after its ack. Required: service order 0,1,2,3 with acks at cycles 11,23,35,47; busy low only in cycles 0,12,24,36.
- Pointer after a grant: serve requester 1, then raise req[0] and req[2] together. Required: requester 2 is served before requester 0.
- Wrap-around: a=0xFF, b=0x01 -> rsp_sum=0x00. a=0x80, b=0x80 -> rsp_sum=0x00.
- Reset mid-RUN: rst=0 in cycle 5 with req[3] held. Required: add_en=0, ack=0, rsp_sum=0, op_cnt=0 immediately. After release, requester 0 wins if raised together with requester 3. Requester 3 alone is re-served with a fresh 12-cycle sequence.
- Withdrawal and saturation: req[1] pulsed for one cycle while busy -> never acked. Force op_cnt to 0xFFFF, complete one operation -> op_cnt stays 0xFFFF.

Source files
------------

// File: rtl/add_serial_rr_ctrl.sv
// add_serial_rr_ctrl: round-robin controller sharing one bit-serial adder among NREQ requesters.
// Grants, loads operands, times the serial add phase, then captures the sum and acks the winner.
module add_serial_rr_ctrl #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   ack,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              busy,
    output logic [CNTW-1:0]   op_cnt,
    output logic              add_en,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_out
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, REL} state_t;
    localparam int PW = $clog2(W);
    localparam logic [PW-1:0] PH_LAST = PW'(W - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [IDW-1:0]  last_q, last_d, gnt_q, gnt_d, pick;
    logic [NREQ-1:0] ack_q, ack_d, req_rot;
    logic            rsp_valid_q, rsp_valid_d, busy_q, busy_d, add_en_q, add_en_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d, add_a_q, add_a_d, add_b_q, add_b_d;
    logic [CNTW-1:0] op_cnt_q, op_cnt_d;
    int              idx;

    // Scan downward so the requester nearest after the last grant is assigned last and wins.
    always_comb begin
        pick = '0;
        idx = 0;
        req_rot = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NREQ;
            req_rot = req >> idx;
            if (req_rot[0]) pick = IDW'(idx);
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d = ph_q;
        gnt_d = gnt_q;
        last_d = last_q;
        add_en_d = 1'b0;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        ack_d = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d = rsp_id_q;
        rsp_sum_d = rsp_sum_q;
        op_cnt_d = op_cnt_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = LOAD;
                gnt_d = pick;
                add_en_d = 1'b1;
                add_a_d = W'(a_in >> (int'(pick) * W));
                add_b_d = W'(b_in >> (int'(pick) * W));
            end
            LOAD: begin
                state_d = RUN;
                ph_d = '0;
            end
            RUN: begin
                ph_d = ph_q + 1'b1;
                state_d = (ph_q == PH_LAST) ? CAPT : RUN;
            end
            CAPT: begin
                state_d = REL;
                rsp_sum_d = add_out;
                rsp_id_d = gnt_q;
                rsp_valid_d = 1'b1;
                ack_d = NREQ'(1) << gnt_q;
            end
            REL: begin
                state_d = IDLE;
                last_d = gnt_q;
                op_cnt_d = (&op_cnt_q) ? op_cnt_q : op_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ph_q <= '0;
            gnt_q <= '0;
            last_q <= IDW'(NREQ - 1);
            add_en_q <= 1'b0;
            add_a_q <= '0;
            add_b_q <= '0;
            ack_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_sum_q <= '0;
            op_cnt_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q <= ph_d;
            gnt_q <= gnt_d;
            last_q <= last_d;
            add_en_q <= add_en_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            ack_q <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_sum_q <= rsp_sum_d;
            op_cnt_q <= op_cnt_d;
            busy_q <= busy_d;
        end
    end

    assign ack = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_sum = rsp_sum_q;
    assign busy = busy_q;
    assign op_cnt = op_cnt_q;
    assign add_en = add_en_q;
    assign add_a = add_a_q;
    assign add_b = add_b_q;
endmodule

// File: tb/tb_add_serial_rr_ctrl.sv
// tb_add_serial_rr_ctrl: directed and randomized bench for add_serial_rr_ctrl.
// A timeline model (cycles since grant) predicts every output; directed literals pin the model.
module tb_add_serial_rr_ctrl;
    localparam int NREQ = 4, W = 8, IDW = 2, CNTW = 16;

    logic clk = 1'b0, rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*W-1:0] a_in = '0, b_in = '0;
    logic [W-1:0] add_out = '0;
    logic [NREQ-1:0] ack;
    logic rsp_valid, busy, add_en;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0] rsp_sum, add_a, add_b;
    logic [CNTW-1:0] op_cnt;

    always #5 clk = ~clk;

    add_serial_rr_ctrl #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .busy(busy), .op_cnt(op_cnt), .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_out(add_out)
    );

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] a_v [NREQ];
    logic [7:0] b_v [NREQ];
    bit m_act;
    int m_t, m_g, m_last;
    logic [7:0] m_a, m_b, e_add_a, e_add_b, e_sum;
    logic [1:0] e_id;
    logic [15:0] m_cnt;
    int ack_ids[$], ack_cyc[$], busy_low[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_t = 0; m_g = 0; m_last = NREQ - 1;
        m_a = 0; m_b = 0; e_add_a = 0; e_add_b = 0; e_sum = 0; e_id = 0; m_cnt = 0;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[i[1:0]]) return i;
        end
        return -1;
    endfunction

    function automatic int onehot_id(input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic advance();
        int g;
        if (m_act) begin
            if (m_t == 10) begin e_sum = m_a + m_b; e_id = 2'(m_g); end
            if (m_t == 11) begin
                m_last = m_g;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_act = 0;
            end else m_t++;
        end else begin
            g = rr_pick(req, m_last);
            if (g >= 0) begin
                m_act = 1; m_t = 1; m_g = g;
                m_a = a_v[g]; m_b = b_v[g];
                e_add_a = m_a; e_add_b = m_b;
            end
        end
    endtask

    task automatic compare();
        logic [3:0] e_ack;
        e_ack = (m_act && m_t == 11) ? 4'(1 << m_g) : 4'd0;
        chk("busy", 32'(busy), 32'(m_act && m_t >= 1));
        chk("add_en", 32'(add_en), 32'(m_act && m_t == 1));
        chk("add_a", 32'(add_a), 32'(e_add_a));
        chk("add_b", 32'(add_b), 32'(e_add_b));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_ack != 0));
        chk("rsp_id", 32'(rsp_id), 32'(e_id));
        chk("rsp_sum", 32'(rsp_sum), 32'(e_sum));
        chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
    endtask

    // Adder stand-in: the true sum appears only in the capture cycle, noise otherwise.
    task automatic step();
        add_out = (m_act && m_t == 10) ? 8'(m_a + m_b) : 8'($urandom);
        a_in = {a_v[3], a_v[2], a_v[1], a_v[0]};
        b_in = {b_v[3], b_v[2], b_v[1], b_v[0]};
        if (!rst) model_reset(); else advance();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic agents();
        for (int i = 0; i < NREQ; i++) begin
            if (m_act && m_t == 11 && m_g == i) begin
                if ($urandom_range(3) == 0) begin a_v[i] = 8'($urandom); b_v[i] = 8'($urandom); end
                else req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1; a_v[i] = 8'($urandom); b_v[i] = 8'($urandom);
                end
            end else if (!(m_act && m_g == i)) begin
                if ($urandom_range(15) == 0) req[i] = 1'b0;
            end else if ($urandom_range(1) == 0) begin
                a_v[i] = 8'($urandom); b_v[i] = 8'($urandom);
            end
        end
    endtask

    task automatic run(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (!busy) busy_low.push_back(cyc);
            if (ack != 0) begin ack_ids.push_back(onehot_id(ack)); ack_cyc.push_back(cyc); end
            if (rnd) agents();
            else if (m_act && m_t == 11) req[m_g[1:0]] = 1'b0;
            step();
        end
    endtask

    task automatic clear_logs();
        ack_ids.delete(); ack_cyc.delete(); busy_low.delete();
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int t0;
        int exp_c[4] = '{11, 23, 35, 47};
        int exp_b[4] = '{0, 12, 24, 36};
        for (int i = 0; i < NREQ; i++) begin a_v[i] = 0; b_v[i] = 0; end
        model_reset();
        #2;
        do_reset();

        // single request
        a_v[0] = 8'h25; b_v[0] = 8'h13; req = 4'b0001;
        step();
        chk("t1_add_en_c1", 32'(add_en), 1);
        chk("t1_add_a", 32'(add_a), 32'h25);
        chk("t1_add_b", 32'(add_b), 32'h13);
        repeat (9) step();
        chk("t1_no_ack_c10", 32'(ack), 0);
        step();
        chk("t1_ack_c11", 32'(ack), 1);
        chk("t1_rsp_valid", 32'(rsp_valid), 1);
        chk("t1_rsp_id", 32'(rsp_id), 0);
        chk("t1_rsp_sum", 32'(rsp_sum), 32'h38);
        req = 4'b0000;
        step();
        chk("t1_op_cnt", 32'(op_cnt), 1);
        chk("t1_ack_gone", 32'(ack), 0);

        // all requesters at once
        do_reset();
        for (int i = 0; i < NREQ; i++) begin a_v[i] = 8'($urandom); b_v[i] = 8'($urandom); end
        clear_logs(); t0 = cyc; req = 4'b1111;
        run(48, 0);
        chk("t2_n_acks", 32'(ack_ids.size()), 4);
        chk("t2_n_busy_low", 32'(busy_low.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", 32'(qget(ack_ids, i)), 32'(i));
            chk("t2_ack_cycle", 32'(qget(ack_cyc, i) - t0), 32'(exp_c[i]));
            chk("t2_busy_low_cycle", 32'(qget(busy_low, i) - t0), 32'(exp_b[i]));
        end

        // wrap-around
        a_v[2] = 8'hFF; b_v[2] = 8'h01; req[2] = 1'b1;
        run(12, 0);
        chk("t4_ff_01", 32'(rsp_sum), 0);
        a_v[2] = 8'h80; b_v[2] = 8'h80; req[2] = 1'b1;
        run(12, 0);
        chk("t4_80_80", 32'(rsp_sum), 0);

        // pointer after a grant
        for (int i = 0; i < NREQ; i++) begin a_v[i] = 8'h11; b_v[i] = 8'h22; end
        clear_logs(); req[1] = 1'b1;
        run(12, 0);
        req[0] = 1'b1; req[2] = 1'b1;
        run(24, 0);
        chk("t3_n_acks", 32'(ack_ids.size()), 3);
        chk("t3_first", 32'(qget(ack_ids, 0)), 1);
        chk("t3_second", 32'(qget(ack_ids, 1)), 2);
        chk("t3_third", 32'(qget(ack_ids, 2)), 0);
        chk("t3_sum", 32'(rsp_sum), 32'h33);

        // reset mid-RUN
        a_v[3] = 8'h40; b_v[3] = 8'h05; req = 4'b1000;
        run(5, 0);
        rst = 1'b0;
        #1;
        chk("t5_add_en", 32'(add_en), 0);
        chk("t5_ack", 32'(ack), 0);
        chk("t5_rsp_sum", 32'(rsp_sum), 0);
        chk("t5_op_cnt", 32'(op_cnt), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_add_a", 32'(add_a), 0);
        model_reset();
        step();
        rst = 1'b1; req[0] = 1'b1; a_v[0] = 8'h07; b_v[0] = 8'h09;
        clear_logs(); t0 = cyc;
        run(24, 0);
        chk("t5_n_acks", 32'(ack_ids.size()), 2);
        chk("t5_first_0", 32'(qget(ack_ids, 0)), 0);
        chk("t5_then_3", 32'(qget(ack_ids, 1)), 3);
        chk("t5_cycle_3", 32'(qget(ack_cyc, 1) - t0), 23);
        req = 4'b1000;
        run(5, 0);
        rst = 1'b0;
        #1;
        chk("t5b_ack", 32'(ack), 0);
        model_reset();
        step();
        rst = 1'b1;
        clear_logs(); t0 = cyc;
        run(14, 0);
        chk("t5b_n_acks", 32'(ack_ids.size()), 1);
        chk("t5b_id", 32'(qget(ack_ids, 0)), 3);
        chk("t5b_latency", 32'(qget(ack_cyc, 0) - t0), 11);
        chk("t5b_sum", 32'(rsp_sum), 32'h45);

        // withdrawal while busy
        clear_logs(); req = 4'b0001;
        run(3, 0);
        req[1] = 1'b1;
        run(1, 0);
        req[1] = 1'b0;
        run(20, 0);
        chk("t6_n_acks", 32'(ack_ids.size()), 1);
        chk("t6_only_0", 32'(qget(ack_ids, 0)), 0);

        // saturation
        force dut.op_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        step();
        release dut.op_cnt_q;
        req[2] = 1'b1;
        run(13, 0);
        chk("t6_cnt_max", 32'(op_cnt), 32'hFFFF);
        req[2] = 1'b1;
        run(13, 0);
        chk("t6_cnt_sat", 32'(op_cnt), 32'hFFFF);

        // randomized traffic with one mid-stream reset
        do_reset();
        run(1500, 1);
        do_reset();
        run(1500, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
